// File: rtl/torus_out_arbiter.sv
// torus_out_arbiter
//   Round-robin arbiter plus single-entry output register for one output
//   port of a 2-D torus NoC router. Up to four upstream switches compete
//   for the port. The winning packet is held until the downstream link
//   accepts it, and cycles of downstream back-pressure are counted.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   [N]        requester i offers a packet
//   in_data    [N*WIDTH]  packet of requester i at [i*WIDTH +: WIDTH]
//   in_ready   [N]        combinational one-hot grant (zero while reset)
//   out_valid             output register holds a packet
//   out_data   [WIDTH]    held packet, passed through unmodified
//   out_src    [2]        requester that supplied out_data
//   out_ready             downstream accepts the held packet
//   stall_cnt  [STALL_W]  saturating count of out_valid && !out_ready cycles
module torus_out_arbiter #(
  parameter int WIDTH   = 39,
  parameter int N       = 4,
  parameter int STALL_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_src,
  input  logic                 out_ready,
  output logic [STALL_W-1:0]   stall_cnt
);

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [1:0]       src_p1;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic             found;
  logic             load;
  logic             grant;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Stage 0: combinational arbitration.
  // Scan from the farthest offset down to offset 0 so that the requester
  // closest to ptr (in rotating order) is the one left in win.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[ptr + 2'(k)]) begin
        win   = ptr + 2'(k);
        found = 1'b1;
      end
    end
  end

  // The register may take a new packet when empty or when its current
  // packet leaves on this same edge (drain-and-refill, no bubble).
  assign load  = !vld_p1 || out_ready;
  assign grant = load && found && !reset;

  always_comb begin
    in_ready = '0;
    if (grant) in_ready[win] = 1'b1;
  end

  // Stage 1: output register, priority pointer and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      src_p1    <= '0;
      ptr       <= '0;
      stall_cnt <= '0;
    end else begin
      if (vld_p1 && !out_ready) stall_cnt <= sat_inc(stall_cnt);
      if (load) begin
        if (found) begin
          vld_p1  <= 1'b1;
          data_p1 <= in_data[int'(win) * WIDTH +: WIDTH];
          src_p1  <= win;
          ptr     <= win + 2'd1;
        end else begin
          vld_p1  <= 1'b0;
        end
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_src   = src_p1;

endmodule
